// File: rtl/alarm_responder.sv
// Alarm responder: ring / snooze / dismiss sequencing with buzzer and status outputs.
// Optional escalation (continuous buzzer) is enabled by defining ALARM_ESCALATE_EN.
module alarm_responder #(
  parameter int TICKS_PER_SEC   = 4,
  parameter int SNOOZE_SECONDS  = 60,
  parameter int RING_TIMEOUT    = 120,
  parameter int MAX_SNOOZE      = 3,
  parameter int BEEP_HALF_TICKS = 1
`ifdef ALARM_ESCALATE_EN
  , parameter int ESCALATE_AFTER = 10
`endif
) (
  input  logic       slow_clk,
  input  logic       reset,
  input  logic       alarm_trigger,
  input  logic       snooze_press,
  input  logic       dismiss_press,
  output logic       buzzer,
  output logic       ringing,
  output logic       snoozed,
  output logic [7:0] snooze_left,
  output logic [3:0] snoozes_used,
  output logic [1:0] state
);

  localparam int PW = (TICKS_PER_SEC > 1) ? $clog2(TICKS_PER_SEC) : 1;
  localparam int BW = (BEEP_HALF_TICKS > 1) ? $clog2(BEEP_HALF_TICKS) : 1;
  localparam logic [PW-1:0] PRESC_MAX    = PW'(TICKS_PER_SEC - 1);
  localparam logic [BW-1:0] BEEP_MAX     = BW'(BEEP_HALF_TICKS - 1);
  localparam logic [7:0]    SNOOZE_LOAD  = 8'(SNOOZE_SECONDS);
  localparam logic [7:0]    RING_LOAD    = 8'(RING_TIMEOUT);
  localparam logic [3:0]    SNOOZE_LIMIT = 4'(MAX_SNOOZE);

  typedef enum logic [1:0] {
    IDLE      = 2'b00,
    RINGING   = 2'b01,
    SNOOZED   = 2'b10,
    DISMISSED = 2'b11
  } state_t;

  state_t        state_r, state_n;
  logic [PW-1:0] presc_r, presc_n;
  logic [BW-1:0] beep_r, beep_n;
  logic [7:0]    ring_timer_r, ring_timer_n;
  logic [7:0]    snooze_left_n;
  logic [3:0]    snoozes_used_n;
  logic          buzzer_n;
  logic          trig_q, snz_q, dis_q;
  logic          trig_edge, snz_edge, dis_edge;
  logic          tick, enter_ring, enter_snz;

  assign trig_edge = alarm_trigger & ~trig_q;
  assign snz_edge  = snooze_press  & ~snz_q;
  assign dis_edge  = dismiss_press & ~dis_q;
  assign tick      = (presc_r == PRESC_MAX);
  assign state     = state_r;

`ifdef ALARM_ESCALATE_EN
  localparam logic [8:0] ESC_SECS = 9'(ESCALATE_AFTER);
  logic       cont_r, cont_n;
  logic [8:0] ring_elapsed;
  // Seconds spent in the current ring once the pending tick is counted.
  assign ring_elapsed = {1'b0, RING_LOAD} - {1'b0, ring_timer_r} + 9'd1;
`endif

  always_ff @(posedge slow_clk) begin
    if (reset) begin
      state_r      <= IDLE;
      presc_r      <= '0;
      beep_r       <= '0;
      ring_timer_r <= '0;
      snooze_left  <= '0;
      snoozes_used <= '0;
      buzzer       <= 1'b0;
      ringing      <= 1'b0;
      snoozed      <= 1'b0;
      trig_q       <= 1'b0;
      snz_q        <= 1'b0;
      dis_q        <= 1'b0;
`ifdef ALARM_ESCALATE_EN
      cont_r       <= 1'b0;
`endif
    end else begin
      state_r      <= state_n;
      presc_r      <= presc_n;
      beep_r       <= beep_n;
      ring_timer_r <= ring_timer_n;
      snooze_left  <= snooze_left_n;
      snoozes_used <= snoozes_used_n;
      buzzer       <= buzzer_n;
      ringing      <= (state_n == RINGING);
      snoozed      <= (state_n == SNOOZED);
      trig_q       <= alarm_trigger;
      snz_q        <= snooze_press;
      dis_q        <= dismiss_press;
`ifdef ALARM_ESCALATE_EN
      cont_r       <= cont_n;
`endif
    end
  end

  always_comb begin
    state_n        = state_r;
    presc_n        = tick ? '0 : presc_r + PW'(1);
    beep_n         = beep_r;
    ring_timer_n   = ring_timer_r;
    snooze_left_n  = snooze_left;
    snoozes_used_n = snoozes_used;
    buzzer_n       = 1'b0;
    enter_ring     = 1'b0;
    enter_snz      = 1'b0;

    case (state_r)
      IDLE: begin
        if (trig_edge) begin
          state_n        = RINGING;
          snoozes_used_n = '0;
          enter_ring     = 1'b1;
        end
      end
      RINGING: begin
        if (dis_edge) begin
          state_n = DISMISSED;
        end else if (snz_edge && (snoozes_used < SNOOZE_LIMIT)) begin
          state_n        = SNOOZED;
          snooze_left_n  = SNOOZE_LOAD;
          snoozes_used_n = snoozes_used + 4'd1;
          enter_snz      = 1'b1;
        end else if (tick) begin
          if (ring_timer_r == 8'd1) state_n = DISMISSED;
          else ring_timer_n = ring_timer_r - 8'd1;
        end
      end
      SNOOZED: begin
        if (dis_edge) begin
          state_n       = DISMISSED;
          snooze_left_n = '0;
        end else if (tick) begin
          if (snooze_left == 8'd1) begin
            state_n       = RINGING;
            snooze_left_n = '0;
            enter_ring    = 1'b1;
          end else begin
            snooze_left_n = snooze_left - 8'd1;
          end
        end
      end
      DISMISSED: begin
        // Wait for the comparator to release so a still-matching time cannot re-ring.
        if (!alarm_trigger) state_n = IDLE;
      end
      default: state_n = IDLE;
    endcase

    if (enter_ring) begin
      ring_timer_n = RING_LOAD;
      presc_n      = '0;
      beep_n       = '0;
      buzzer_n     = 1'b1;
    end else if (state_n == RINGING) begin
      if (beep_r == BEEP_MAX) begin
        beep_n   = '0;
        buzzer_n = ~buzzer;
      end else begin
        beep_n   = beep_r + BW'(1);
        buzzer_n = buzzer;
      end
    end

    if (enter_snz) presc_n = '0;

`ifdef ALARM_ESCALATE_EN
    cont_n = 1'b0;
    if (enter_ring)
      cont_n = (state_r == SNOOZED) && (snoozes_used_n >= 4'd2);
    else if (state_n == RINGING)
      cont_n = cont_r || (tick && (ring_elapsed >= ESC_SECS));
    if ((state_n == RINGING) && cont_n) buzzer_n = 1'b1;
`endif
  end

endmodule

// File: tb/tb_alarm_responder.sv
// Bench for alarm_responder: directed vector table, corner-case sequences and
// randomized traffic checked against a cycle-count based reference model.
module tb_alarm_responder;

  localparam int TPS = 2;
  localparam int SS  = 3;
  localparam int RT  = 5;
  localparam int MS  = 2;
  localparam int BH  = 1;

  logic       slow_clk = 1'b0;
  logic       reset = 1'b1;
  logic       alarm_trigger = 1'b0;
  logic       snooze_press = 1'b0;
  logic       dismiss_press = 1'b0;
  logic       buzzer, ringing, snoozed;
  logic [7:0] snooze_left;
  logic [3:0] snoozes_used;
  logic [1:0] state;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 slow_clk = ~slow_clk;

  alarm_responder #(
    .TICKS_PER_SEC  (TPS),
    .SNOOZE_SECONDS (SS),
    .RING_TIMEOUT   (RT),
    .MAX_SNOOZE     (MS),
    .BEEP_HALF_TICKS(BH)
  ) dut (
    .slow_clk     (slow_clk),
    .reset        (reset),
    .alarm_trigger(alarm_trigger),
    .snooze_press (snooze_press),
    .dismiss_press(dismiss_press),
    .buzzer       (buzzer),
    .ringing      (ringing),
    .snoozed      (snoozed),
    .snooze_left  (snooze_left),
    .snoozes_used (snoozes_used),
    .state        (state)
  );

  // Reference model: mode 0 idle, 1 ringing, 2 snoozed, 3 dismissed; m_k counts
  // clock cycles since the current ring or snooze began.
  int   m_st = 0, m_k = 0, m_used = 0;
  logic m_pt = 0, m_ps = 0, m_pd = 0;

  function automatic void model_edge(input logic r, t, s, d);
    logic te, se, de;
    if (r) begin
      m_st = 0; m_k = 0; m_used = 0; m_pt = 0; m_ps = 0; m_pd = 0;
      return;
    end
    te = t & ~m_pt;
    se = s & ~m_ps;
    de = d & ~m_pd;
    case (m_st)
      0: if (te) begin m_st = 1; m_k = 0; m_used = 0; end
      1: begin
        if (de) m_st = 3;
        else if (se && m_used < MS) begin m_st = 2; m_k = 0; m_used++; end
        else if (m_k + 1 == RT * TPS) m_st = 3;
        else m_k++;
      end
      2: begin
        if (de) m_st = 3;
        else if (m_k + 1 == SS * TPS) begin m_st = 1; m_k = 0; end
        else m_k++;
      end
      default: if (!t) m_st = 0;
    endcase
    m_pt = t; m_ps = s; m_pd = d;
  endfunction

  task automatic cycle(input logic r, t, s, d);
    @(negedge slow_clk);
    reset = r; alarm_trigger = t; snooze_press = s; dismiss_press = d;
    @(posedge slow_clk);
    model_edge(r, t, s, d);
    #1;
  endtask

  task automatic check(input string nm, input logic [1:0] e_st, input logic e_bz,
                       input logic [7:0] e_left, input logic [3:0] e_used);
    logic [15:0] got, want;
    got  = {state, buzzer, ringing, snoozed, snooze_left, snoozes_used[2:0]};
    want = {e_st, e_bz, e_st == 2'd1, e_st == 2'd2, e_left, e_used[2:0]};
    n_cmp++;
    if (got != want || snoozes_used[3] != e_used[3]) begin
      n_bad++;
      $display("FAIL %s: got st=%0d bz=%0d rg=%0d sz=%0d left=%0d used=%0d, want st=%0d bz=%0d left=%0d used=%0d",
               nm, state, buzzer, ringing, snoozed, snooze_left, snoozes_used,
               e_st, e_bz, e_left, e_used);
    end
  endtask

  task automatic check_model(input string nm);
    logic       bz;
    logic [7:0] left;
    bz   = (m_st == 1) && (((m_k / BH) % 2) == 0);
    left = (m_st == 2) ? 8'(SS - m_k / TPS) : 8'd0;
    check(nm, 2'(m_st), bz, left, 4'(m_used));
  endtask

  typedef struct {
    logic       r, t, s, d;
    logic [1:0] st;
    logic       bz;
    logic [7:0] left;
    logic [3:0] used;
  } vec_t;

  vec_t tbl[23];

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    int cnt;
    logic t, s, d, r;

    tbl[0]  = '{1, 1, 0, 0, 2'd0, 0, 8'd0, 4'd0};
    tbl[1]  = '{1, 1, 0, 0, 2'd0, 0, 8'd0, 4'd0};
    tbl[2]  = '{0, 1, 0, 0, 2'd1, 1, 8'd0, 4'd0};
    tbl[3]  = '{0, 1, 0, 0, 2'd1, 0, 8'd0, 4'd0};
    tbl[4]  = '{0, 1, 0, 0, 2'd1, 1, 8'd0, 4'd0};
    tbl[5]  = '{0, 1, 0, 1, 2'd3, 0, 8'd0, 4'd0};
    tbl[6]  = '{0, 1, 0, 0, 2'd3, 0, 8'd0, 4'd0};
    tbl[7]  = '{0, 1, 0, 0, 2'd3, 0, 8'd0, 4'd0};
    tbl[8]  = '{0, 1, 0, 0, 2'd3, 0, 8'd0, 4'd0};
    tbl[9]  = '{0, 1, 0, 0, 2'd3, 0, 8'd0, 4'd0};
    tbl[10] = '{0, 1, 0, 0, 2'd3, 0, 8'd0, 4'd0};
    tbl[11] = '{0, 0, 0, 0, 2'd0, 0, 8'd0, 4'd0};
    tbl[12] = '{0, 1, 0, 0, 2'd1, 1, 8'd0, 4'd0};
    tbl[13] = '{0, 1, 1, 0, 2'd2, 0, 8'd3, 4'd1};
    tbl[14] = '{0, 1, 1, 0, 2'd2, 0, 8'd3, 4'd1};
    tbl[15] = '{0, 0, 0, 0, 2'd2, 0, 8'd2, 4'd1};
    tbl[16] = '{0, 0, 0, 0, 2'd2, 0, 8'd2, 4'd1};
    tbl[17] = '{0, 0, 0, 0, 2'd2, 0, 8'd1, 4'd1};
    tbl[18] = '{0, 0, 0, 0, 2'd2, 0, 8'd1, 4'd1};
    tbl[19] = '{0, 0, 0, 0, 2'd1, 1, 8'd0, 4'd1};
    tbl[20] = '{0, 0, 0, 0, 2'd1, 0, 8'd0, 4'd1};
    tbl[21] = '{0, 0, 0, 1, 2'd3, 0, 8'd0, 4'd1};
    tbl[22] = '{0, 0, 0, 0, 2'd0, 0, 8'd0, 4'd1};

    for (int i = 0; i < 23; i++) begin
      cycle(tbl[i].r, tbl[i].t, tbl[i].s, tbl[i].d);
      check($sformatf("vec%0d", i), tbl[i].st, tbl[i].bz, tbl[i].left, tbl[i].used);
    end

    // Snooze limit and auto-dismiss timing.
    cycle(1, 0, 0, 0);
    cycle(0, 1, 0, 0);
    check_model("limit_ring");
    for (int n = 0; n < MS; n++) begin
      cycle(0, 1, 1, 0);
      check_model("limit_snooze");
      cnt = 0;
      do begin
        cycle(0, 1, 0, 0);
        check_model("limit_wait");
        cnt++;
      end while (state != 2'd1 && cnt < 20);
    end
    cnt = 1;
    cycle(0, 1, 1, 0);
    check("limit_third", 2'd1, 1'b0, 8'd0, 4'd2);
    do begin
      cycle(0, 1, 0, 0);
      check_model("limit_timeout");
      cnt++;
    end while (state != 2'd3 && cnt < 30);
    n_cmp++;
    if (cnt != RT * TPS) begin
      n_bad++;
      $display("FAIL limit_timeout_cycles: got %0d want %0d", cnt, RT * TPS);
    end

    // Simultaneous snooze and dismiss: dismiss wins.
    cycle(0, 0, 0, 0);
    cycle(0, 1, 0, 0);
    cycle(0, 1, 1, 1);
    check("simul_press", 2'd3, 1'b0, 8'd0, 4'd0);

    // Reset in the middle of a snooze.
    cycle(0, 0, 0, 0);
    cycle(0, 1, 0, 0);
    cycle(0, 1, 1, 0);
    cycle(0, 1, 0, 0);
    cycle(0, 1, 0, 0);
    check_model("pre_reset_snooze");
    cycle(1, 0, 0, 0);
    check("reset_mid_snooze", 2'd0, 1'b0, 8'd0, 4'd0);

    // Buttons in IDLE are ignored; trigger falling mid-ring has no effect.
    cycle(0, 0, 1, 0);
    check("idle_snooze", 2'd0, 1'b0, 8'd0, 4'd0);
    cycle(0, 0, 0, 1);
    check("idle_dismiss", 2'd0, 1'b0, 8'd0, 4'd0);
    cycle(0, 1, 0, 0);
    for (int i = 0; i < 4; i++) begin
      cycle(0, 0, 0, 0);
      check_model("trig_fall_ring");
    end

    // Randomized traffic against the model.
    t = 0;
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 19) == 0) t = ~t;
      s = ($urandom_range(0, 5) == 0);
      d = ($urandom_range(0, 14) == 0);
      r = ($urandom_range(0, 299) == 0);
      cycle(r, t, s, d);
      check_model("random");
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
